// File: rtl/mult_div.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// Operations run for a fixed number of cycles; results land as Busy falls.
module mult_div #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  MDUOp,
    input  logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [2:0]    op_q,    op_d;
    logic [31:0]   a_q,     a_d;
    logic [31:0]   b_q,     b_d;
    logic [31:0]   hi_q,    hi_d;
    logic [31:0]   lo_q,    lo_d;

    // Multiply: sign- or zero-extend to 64 bits; the low 64 bits of the product are exact either way.
    logic        mul_signed;
    logic [63:0] a_ext, b_ext, prod;

    assign mul_signed = (op_q == OP_MULT);
    assign a_ext      = {{32{mul_signed & a_q[31]}}, a_q};
    assign b_ext      = {{32{mul_signed & b_q[31]}}, b_q};
    assign prod       = a_ext * b_ext;

    // Divide on magnitudes so 0x80000000 / -1 wraps cleanly to 0x80000000.
    logic        div_signed, a_neg, b_neg, b_zero;
    logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

    assign div_signed = (op_q == OP_DIV);
    assign a_neg      = div_signed & a_q[31];
    assign b_neg      = div_signed & b_q[31];
    assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
    assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
    assign b_zero     = (b_q == 32'd0);
    assign b_safe     = b_zero ? 32'd1 : b_mag;
    assign q_mag      = a_mag / b_safe;
    assign r_mag      = a_mag % b_safe;
    assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (MDUOp)
                        OP_MULT, OP_MULTU: begin
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(MULT_CYCLES - 1);
                            state_d = S_RUN;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = MDUOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = CW'(DIV_CYCLES - 1);
                            state_d = S_RUN;
                        end
                        OP_MTHI: hi_d = A;
                        OP_MTLO: lo_d = A;
                        default: ;
                    endcase
                end
            end
            default: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (op_q == OP_MULT || op_q == OP_MULTU) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!b_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign Busy = (state_q == S_RUN);
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div.sv
// Self-checking bench for mult_div: directed corner cases, then random
// operations compared against an arithmetic reference model.
module tb_mult_div;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [2:0]  MDUOp = '0;
    logic        Start = 1'b0;
    logic        Busy;
    logic [31:0] HI, LO;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .MDUOp (MDUOp),
        .Start (Start),
        .Busy  (Busy),
        .HI    (HI),
        .LO    (LO)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_state(input string tag, input logic busy_exp);
        chk({tag, ".busy"}, {31'd0, Busy}, {31'd0, busy_exp});
        chk({tag, ".hi"}, HI, exp_hi);
        chk({tag, ".lo"}, LO, exp_lo);
    endtask

    // Reference model: returns the new {HI,LO} after an accepted op.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] hi,
                                           input logic [31:0] lo);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = {32'd0, a};
        longint unsigned ub = {32'd0, b};
        logic [63:0]     r  = {hi, lo};
        case (op)
            3'd1: r = 64'(sa * sb);
            3'd2: r = 64'(ua * ub);
            3'd3: if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
            3'd4: if (b != 0) r = {32'(ua % ub), 32'(ua / ub)};
            3'd5: r = {a, lo};
            3'd6: r = {hi, a};
            default: ;
        endcase
        return r;
    endfunction

    function automatic int busy_len(input logic [2:0] op);
        if (op == 3'd1 || op == 3'd2) return 5;
        if (op == 3'd3 || op == 3'd4) return 10;
        return 0;
    endfunction

    // Issue at the current negedge; ends at a negedge with Busy=0 and results checked.
    // noise=1 asserts random Starts during Busy; inj_cycle forces a specific one.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit noise, input int inj_cycle,
                          input logic [2:0] inj_op, input logic [31:0] inj_a);
        logic [63:0] nxt;
        int n;
        nxt   = ref_op(op, a, b, exp_hi, exp_lo);
        n     = busy_len(op);
        A     = a;
        B     = b;
        MDUOp = op;
        Start = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            A     = $urandom;
            B     = $urandom;
            MDUOp = 3'($urandom_range(0, 7));
            Start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            chk_state({tag, ".run"}, 1'b1);
            if (i == inj_cycle) begin
                A     = inj_a;
                MDUOp = inj_op;
                Start = 1'b1;
            end
        end
        @(negedge clk);
        Start = 1'b0;
        {exp_hi, exp_lo} = nxt;
        chk_state({tag, ".done"}, 1'b0);
        $display("op=%0d A=%h B=%h -> HI=%h LO=%h (%s)", op, a, b, HI, LO, tag);
    endtask

    task automatic idle_cycle(input string tag);
        @(negedge clk);
        chk_state(tag, 1'b0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        // Asynchronous reset, then Start held during reset must be ignored.
        #2 reset = 1'b1;
        #1 chk_state("reset_async", 1'b0);
        A = 32'h1234_5678; MDUOp = 3'd5; Start = 1'b1;
        @(negedge clk);
        chk_state("start_in_reset", 1'b0);
        Start = 1'b0;
        reset = 1'b0;
        idle_cycle("post_reset");

        run_op("mult_neg2x3",  3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 3'd0, 32'd0);
        chk("mult_hi_const", HI, 32'hFFFF_FFFF);
        chk("mult_lo_const", LO, 32'hFFFF_FFFA);
        run_op("multu_neg2x3", 3'd2, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, 3'd0, 32'd0);
        chk("multu_hi_const", HI, 32'h0000_0002);
        run_op("div_m7_2",     3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, 3'd0, 32'd0);
        chk("div_lo_const", LO, 32'hFFFF_FFFD);
        chk("div_hi_const", HI, 32'hFFFF_FFFF);
        run_op("divu_7_2",     3'd4, 32'd7, 32'd2, 1'b0, 0, 3'd0, 32'd0);
        run_op("mthi_11",      3'd5, 32'h11, 32'd0, 1'b0, 0, 3'd0, 32'd0);
        run_op("mtlo_22",      3'd6, 32'h22, 32'd0, 1'b0, 0, 3'd0, 32'd0);
        run_op("div_by_zero",  3'd3, 32'h1234, 32'd0, 1'b0, 0, 3'd0, 32'd0);
        chk("divz_hi_const", HI, 32'h11);
        chk("divz_lo_const", LO, 32'h22);
        run_op("div_overflow", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, 3'd0, 32'd0);
        chk("divovf_lo_const", LO, 32'h8000_0000);
        run_op("mult_mthi_ign", 3'd1, 32'd1000, 32'hFFFF_FF00, 1'b0, 3, 3'd5, 32'hDEAD_BEEF);
        idle_cycle("idle_gap");
        run_op("mtlo_5",       3'd6, 32'h5, 32'd0, 1'b0, 0, 3'd0, 32'd0);
        // Back-to-back: each run_op drives Start in the first Busy=0 cycle of the previous one.
        run_op("b2b_first",    3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 0, 3'd0, 32'd0);
        run_op("b2b_second",   3'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0, 3'd0, 32'd0);

        // Reset in the 4th cycle of a DIV discards it.
        A = 32'd1000; B = 32'd7; MDUOp = 3'd3; Start = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            Start = 1'b0;
            chk_state("div_pre_reset", 1'b1);
        end
        #2 reset = 1'b1;
        exp_hi = '0;
        exp_lo = '0;
        #1 chk_state("reset_mid_div", 1'b0);
        #1 reset = 1'b0;
        for (int i = 0; i < 20; i++) idle_cycle("post_reset_quiet");

        // Random operations with Start noise during Busy.
        for (int k = 0; k < 60; k++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) rb = 32'hFFFF_FFFF;
            if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
            run_op("random", rop, ra, rb, 1'b1, 0, 3'd0, 32'd0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle_cycle("random_gap");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_div.md
MULT_DIV -- requirements
Module: mult_div

Interface
REQ-001 The block SHALL expose parameter MULT_CYCLES, default 5, the number of cycles Busy stays high for MULT/MULTU.
REQ-002 The block SHALL expose parameter DIV_CYCLES, default 10, the number of cycles Busy stays high for DIV/DIVU.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL change on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port A, input, 32 bits: operand rs (multiplicand or dividend; MTHI/MTLO source).
REQ-006 Port B, input, 32 bits: operand rt (multiplier or divisor).
REQ-007 Port MDUOp, input, 3 bits: operation code 0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; codes 7 and up SHALL be treated as NONE.
REQ-008 Port Start, input, 1 bit: high for one cycle to issue MDUOp with the current A and B.
REQ-009 Port Busy, output, 1 bit: an operation is in flight.
REQ-010 Port HI, output, 32 bits: architectural HI register.
REQ-011 Port LO, output, 32 bits: architectural LO register.

Function
REQ-012 The block SHALL have states IDLE and RUN, plus a down-counter sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, Start=1 with MULT, MULTU, DIV or DIVU SHALL latch the operation and operands, load the counter, and enter RUN at that edge.
REQ-014 Busy SHALL equal (state==RUN) and SHALL be high for exactly MULT_CYCLES or DIV_CYCLES consecutive cycles, starting the cycle after the accepting edge.
REQ-015 HI and LO SHALL update on the edge that ends the last Busy cycle, and the new values SHALL be visible in the same cycle Busy returns to 0.
REQ-016 While the block is in RUN, HI and LO SHALL hold their previous values.
REQ-017 In IDLE, Start=1 with MTHI SHALL write A to HI at that edge with no Busy assertion and LO unchanged; MTLO SHALL do the same to LO.
REQ-018 Start SHALL be ignored while Busy=1 for every MDUOp, including MTHI and MTLO; there is no queueing.
REQ-019 Start=1 with NONE SHALL be ignored.
REQ-020 MULT SHALL set {HI,LO} = signed(A)*signed(B), full 64 bits; MULTU SHALL compute the same with both operands unsigned.
REQ-021 DIV SHALL set LO = signed quotient truncated toward zero, and HI = remainder carrying the sign of the dividend.
REQ-022 DIVU SHALL set LO = unsigned quotient and HI = unsigned remainder.
REQ-023 DIV with A=0x80000000 and B=0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000, with no exception.
REQ-024 DIV or DIVU with B=0 SHALL still run the full DIV_CYCLES, and HI and LO SHALL remain unchanged at completion.
REQ-025 Results SHALL depend only on the operands latched at acceptance; A and B changing during RUN SHALL have no effect.
REQ-026 A new Start SHALL be accepted in the first cycle Busy=0 after completion, giving back-to-back issue with no dead cycle.

Reset
REQ-027 When reset=1, HI, LO, Busy, the counter and the latched operands SHALL clear to 0 immediately, with no clock required, and the state SHALL return to IDLE.
REQ-028 Reset asserted mid-operation SHALL discard the in-flight result, and no HI/LO write SHALL occur after reset is released.
REQ-029 Start SHALL be ignored in any cycle where reset=1.

Verification
REQ-030 MULT with A=0xFFFFFFFE (-2) and B=0x00000003 -> Busy high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-031 DIV with A=0xFFFFFFF9 (-7) and B=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; DIVU with A=7, B=2 -> LO=3, HI=1.
REQ-032 With HI=0x11 and LO=0x22, DIV with B=0 -> Busy high for 10 cycles, then HI=0x11 and LO=0x22; DIV with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 MTHI with A=0xDEADBEEF issued during a MULT's third Busy cycle -> ignored, and the MULT result lands; MTLO with A=0x5 in IDLE -> LO=0x5 the next cycle, Busy stays 0.
REQ-034 Reset pulsed asynchronously in the 4th cycle of a DIV -> HI=LO=0 and Busy=0 immediately; after release, no further change for 20 cycles.
REQ-035 Two MULTs issued back-to-back, the second in the first cycle Busy=0 -> second accepted, Busy low for exactly 1 cycle between them, and both results correct in turn.
